// File: rtl/secded_scrub_regfile.sv
// SECDED (extended Hamming) protected register file with background scrubber,
// write-back repair, saturating error counters and a fault-injection port.
// Codeword layout: bit 0 is overall even parity; bits 1..CW-1 are Hamming
// positions, with check bits at power-of-two positions and data elsewhere.
module secded_scrub_regfile #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned SCRUB_PERIOD = 16,
    parameter int unsigned CNT_WIDTH    = 8,
    localparam int unsigned P0 = $clog2(DATA_WIDTH + 1),
    localparam int unsigned P  = ((2 ** P0) >= (DATA_WIDTH + P0 + 1)) ? P0 : P0 + 1,
    localparam int unsigned CW = DATA_WIDTH + P + 1,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  rerr_single_o,
    output logic                  rerr_double_o,
    input  logic                  scrub_en_i,
    output logic                  scrub_busy_o,
    input  logic                  clr_cnt_i,
    output logic [CNT_WIDTH-1:0]  corr_cnt_o,
    output logic [CNT_WIDTH-1:0]  uncorr_cnt_o,
    input  logic                  inj_en_i,
    input  logic [AW-1:0]         inj_addr_i,
    input  logic [CW-1:0]         inj_mask_i
);

    localparam int unsigned WW = $clog2(SCRUB_PERIOD + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_FIX} state_t;

    function automatic logic is_pow2(input int unsigned i);
        return (i & (i - 1)) == 0;
    endfunction

    function automatic logic [P-1:0] syndrome(input logic [CW-1:0] cw);
        logic [P-1:0] s;
        s = '0;
        for (int unsigned i = 1; i < CW; i++) begin
            if (cw[i]) s = s ^ P'(i);
        end
        return s;
    endfunction

    function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
        logic [CW-1:0] cw;
        logic [P-1:0]  s;
        int unsigned   k;
        cw = '0;
        k  = 0;
        for (int unsigned i = 1; i < CW; i++) begin
            if (!is_pow2(i)) begin
                cw[i] = d[k];
                k++;
            end
        end
        s = syndrome(cw);
        for (int unsigned j = 0; j < P; j++) begin
            cw[1 << j] = s[j];
        end
        cw[0] = ^cw[CW-1:1];
        return cw;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] get_data(input logic [CW-1:0] cw);
        logic [DATA_WIDTH-1:0] d;
        int unsigned           k;
        d = '0;
        k = 0;
        for (int unsigned i = 1; i < CW; i++) begin
            if (!is_pow2(i)) begin
                d[k] = cw[i];
                k++;
            end
        end
        return d;
    endfunction

    // Flip the bit named by the syndrome when overall parity is bad; syndrome 0 means bit 0.
    function automatic logic [CW-1:0] correct(input logic [CW-1:0] cw);
        logic [CW-1:0] c;
        logic [P-1:0]  s;
        c = cw;
        s = syndrome(cw);
        if (^cw) begin
            for (int unsigned i = 0; i < CW; i++) begin
                if (P'(i) == s) c[i] = ~c[i];
            end
        end
        return c;
    endfunction

    logic [CW-1:0]  mem [DEPTH];
    state_t         state;
    logic [AW-1:0]  ptr;
    logic [WW-1:0]  wcnt;
    logic [CW-1:0]  fix_cw;
    logic           fix_cancel;

    logic [CW-1:0]  rd_cw_c;
    logic [CW-1:0]  sc_cw_c;
    logic           sc_single_c;
    logic           sc_double_c;
    logic           ptr_hit_c;
    logic           fix_we_c;
    logic           inc_corr_c;
    logic           inc_uncorr_c;
    logic [AW-1:0]  ptr_next_c;

    // Read and scrub decode inputs; out-of-range reads see the clean all-zero codeword.
    always_comb begin
        rd_cw_c      = '0;
        if (32'(raddr_i) < DEPTH) rd_cw_c = mem[raddr_i];
        sc_cw_c      = mem[ptr];
        sc_single_c  = ^sc_cw_c;
        sc_double_c  = !sc_single_c && (syndrome(sc_cw_c) != '0);
        ptr_hit_c    = we_i && (waddr_i == ptr);
        fix_we_c     = (state == S_FIX) && !fix_cancel;
        inc_corr_c   = (state == S_CHECK) && scrub_en_i && sc_single_c;
        inc_uncorr_c = (state == S_CHECK) && scrub_en_i && sc_double_c;
        ptr_next_c   = (32'(ptr) == DEPTH - 1) ? '0 : ptr + AW'(1);
    end

    // Storage update with per-entry priority: user write > scrub fix > injection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (we_i && (waddr_i == AW'(i))) begin
                    mem[i] <= encode(wdata_i);
                end else if (fix_we_c && (ptr == AW'(i))) begin
                    mem[i] <= fix_cw;
                end else if (inj_en_i && (inj_addr_i == AW'(i))) begin
                    mem[i] <= mem[i] ^ inj_mask_i;
                end
            end
        end
    end

    // Registered read port: data and flags update only on a read strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o      <= 1'b0;
            rdata_o       <= '0;
            rerr_single_o <= 1'b0;
            rerr_double_o <= 1'b0;
        end else begin
            rvalid_o <= re_i;
            if (re_i) begin
                rdata_o       <= get_data(correct(rd_cw_c));
                rerr_single_o <= ^rd_cw_c;
                rerr_double_o <= !(^rd_cw_c) && (syndrome(rd_cw_c) != '0);
            end
        end
    end

    // Scrub FSM: wait, check one entry, optionally write back its correction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            ptr          <= '0;
            wcnt         <= '0;
            fix_cw       <= '0;
            fix_cancel   <= 1'b0;
            scrub_busy_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (scrub_en_i) begin
                        state        <= S_WAIT;
                        wcnt         <= WW'(SCRUB_PERIOD - 1);
                        scrub_busy_o <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!scrub_en_i) begin
                        state        <= S_IDLE;
                        scrub_busy_o <= 1'b0;
                    end else if (wcnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        wcnt <= wcnt - WW'(1);
                    end
                end
                S_CHECK: begin
                    if (!scrub_en_i) begin
                        state        <= S_IDLE;
                        scrub_busy_o <= 1'b0;
                    end else if (sc_single_c) begin
                        fix_cw     <= correct(sc_cw_c);
                        fix_cancel <= ptr_hit_c;
                        state      <= S_FIX;
                    end else begin
                        ptr   <= ptr_next_c;
                        wcnt  <= WW'(SCRUB_PERIOD - 1);
                        state <= S_WAIT;
                    end
                end
                default: begin
                    ptr <= ptr_next_c;
                    if (scrub_en_i) begin
                        wcnt  <= WW'(SCRUB_PERIOD - 1);
                        state <= S_WAIT;
                    end else begin
                        state        <= S_IDLE;
                        scrub_busy_o <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Saturating error counters; clear beats a same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            corr_cnt_o   <= '0;
            uncorr_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            corr_cnt_o   <= '0;
            uncorr_cnt_o <= '0;
        end else begin
            if (inc_corr_c && (corr_cnt_o != '1))     corr_cnt_o   <= corr_cnt_o + CNT_WIDTH'(1);
            if (inc_uncorr_c && (uncorr_cnt_o != '1)) uncorr_cnt_o <= uncorr_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_secded_scrub_regfile.sv
// Bench for secded_scrub_regfile: a default-sized instance for read/write/scrub
// behaviour and a small CNT_WIDTH=2, DEPTH=6 instance for saturation and range.
module tb_secded_scrub_regfile;

    localparam int unsigned CW = 39;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults (32-bit data, 8 entries, period 16, 8-bit counters)
    logic          we, re, scrub_en, clr_cnt, inj_en;
    logic [2:0]    waddr, raddr, inj_addr;
    logic [31:0]   wdata, rdata;
    logic [CW-1:0] inj_mask;
    logic          rvalid, rerr_single, rerr_double, scrub_busy;
    logic [7:0]    corr_cnt, uncorr_cnt;

    secded_scrub_regfile dut (
        .clk_i(clk), .rst_i(rst),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
        .rerr_single_o(rerr_single), .rerr_double_o(rerr_double),
        .scrub_en_i(scrub_en), .scrub_busy_o(scrub_busy), .clr_cnt_i(clr_cnt),
        .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt),
        .inj_en_i(inj_en), .inj_addr_i(inj_addr), .inj_mask_i(inj_mask)
    );

    // Instance B: 6 entries (non power of two), period 2, 2-bit counters
    logic          b_we, b_re, b_scrub_en, b_clr_cnt, b_inj_en;
    logic [2:0]    b_waddr, b_raddr, b_inj_addr;
    logic [31:0]   b_wdata, b_rdata;
    logic [CW-1:0] b_inj_mask;
    logic          b_rvalid, b_rerr_single, b_rerr_double, b_scrub_busy;
    logic [1:0]    b_corr_cnt, b_uncorr_cnt;

    secded_scrub_regfile #(.DATA_WIDTH(32), .DEPTH(6), .SCRUB_PERIOD(2), .CNT_WIDTH(2)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .we_i(b_we), .waddr_i(b_waddr), .wdata_i(b_wdata),
        .re_i(b_re), .raddr_i(b_raddr), .rdata_o(b_rdata), .rvalid_o(b_rvalid),
        .rerr_single_o(b_rerr_single), .rerr_double_o(b_rerr_double),
        .scrub_en_i(b_scrub_en), .scrub_busy_o(b_scrub_busy), .clr_cnt_i(b_clr_cnt),
        .corr_cnt_o(b_corr_cnt), .uncorr_cnt_o(b_uncorr_cnt),
        .inj_en_i(b_inj_en), .inj_addr_i(b_inj_addr), .inj_mask_i(b_inj_mask)
    );

    typedef struct {
        logic          we;
        logic [2:0]    waddr;
        logic [31:0]   wdata;
        logic          re;
        logic [2:0]    raddr;
        logic          inj;
        logic [2:0]    iaddr;
        logic [CW-1:0] imask;
        logic          ev;
        logic [31:0]   ed;
        logic          es;
        logic          edb;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                                input logic r, input logic [2:0] ra,
                                input logic ij, input logic [2:0] ia, input logic [CW-1:0] im,
                                input logic ev, input logic [31:0] ed, input logic es, input logic edb);
        vec_t v;
        v.we = w;  v.waddr = wa; v.wdata = wd;
        v.re = r;  v.raddr = ra;
        v.inj = ij; v.iaddr = ia; v.imask = im;
        v.ev = ev; v.ed = ed; v.es = es; v.edb = edb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_a();
        we = 1'b0; re = 1'b0; inj_en = 1'b0;
    endtask

    // Issue a one-cycle read on instance A and check the result one cycle later.
    task automatic read_a(input logic [2:0] a, input logic [31:0] ed, input logic es,
                          input logic edb, input string name);
        re = 1'b1; raddr = a;
        @(negedge clk);
        re = 1'b0;
        chk({name, " rvalid"}, 64'(rvalid), 64'(1));
        chk({name, " rdata"}, 64'(rdata), 64'(ed));
        chk({name, " single"}, 64'(rerr_single), 64'(es));
        chk({name, " double"}, 64'(rerr_double), 64'(edb));
    endtask

    task automatic read_b(input logic [2:0] a, input string name);
        b_re = 1'b1; b_raddr = a;
        @(negedge clk);
        b_re = 1'b0;
        chk({name, " rvalid"}, 64'(b_rvalid), 64'(1));
        chk({name, " rdata"}, 64'(b_rdata), 64'(0));
        chk({name, " flags"}, 64'({b_rerr_single, b_rerr_double}), 64'(0));
    endtask

    task automatic inject_a(input logic [2:0] a, input logic [CW-1:0] m);
        inj_en = 1'b1; inj_addr = a; inj_mask = m;
        @(negedge clk);
        inj_en = 1'b0;
    endtask

    // Bounded waits on a counter value; expiry shows up as a failed check.
    task automatic wait_uncorr(input logic [7:0] target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (uncorr_cnt == target) break;
            @(negedge clk);
        end
        chk(name, 64'(uncorr_cnt), 64'(target));
    endtask

    task automatic wait_corr(input logic [7:0] target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (corr_cnt == target) break;
            @(negedge clk);
        end
        chk(name, 64'(corr_cnt), 64'(target));
    endtask

    initial begin
        idle_a();
        waddr = '0; wdata = '0; raddr = '0; inj_addr = '0; inj_mask = '0;
        scrub_en = 1'b0; clr_cnt = 1'b0;
        b_we = 1'b0; b_re = 1'b0; b_inj_en = 1'b0; b_scrub_en = 1'b0; b_clr_cnt = 1'b0;
        b_waddr = '0; b_wdata = '0; b_raddr = '0; b_inj_addr = '0; b_inj_mask = '0;

        //            we waddr wdata         re raddr inj iaddr imask       ev  ed            es   edb
        vecs[0]  = mk(0, 3'd0, 32'h0,        1, 3'd3, 0, 3'd0, 39'h0,     1, 32'h0,        0, 0);
        vecs[1]  = mk(1, 3'd2, 32'hDEADBEEF, 0, 3'd0, 0, 3'd0, 39'h0,     0, 32'h0,        0, 0);
        vecs[2]  = mk(0, 3'd0, 32'h0,        1, 3'd2, 0, 3'd0, 39'h0,     1, 32'hDEADBEEF, 0, 0);
        vecs[3]  = mk(1, 3'd2, 32'h1,        1, 3'd2, 0, 3'd0, 39'h0,     1, 32'hDEADBEEF, 0, 0);
        vecs[4]  = mk(0, 3'd0, 32'h0,        1, 3'd2, 0, 3'd0, 39'h0,     1, 32'h1,        0, 0);
        vecs[5]  = mk(1, 3'd2, 32'hDEADBEEF, 0, 3'd0, 0, 3'd0, 39'h0,     0, 32'h1,        0, 0);
        vecs[6]  = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 3'd2, 39'h20,    0, 32'h1,        0, 0);
        vecs[7]  = mk(0, 3'd0, 32'h0,        1, 3'd2, 0, 3'd0, 39'h0,     1, 32'hDEADBEEF, 1, 0);
        vecs[8]  = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 3'd5, 39'h3,     0, 32'hDEADBEEF, 1, 0);
        vecs[9]  = mk(0, 3'd0, 32'h0,        1, 3'd5, 0, 3'd0, 39'h0,     1, 32'h0,        0, 1);
        vecs[10] = mk(1, 3'd3, 32'h0F0F0F0F, 0, 3'd0, 0, 3'd0, 39'h0,     0, 32'h0,        0, 1);
        vecs[11] = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 3'd3, 39'h1,     0, 32'h0,        0, 1);
        vecs[12] = mk(0, 3'd0, 32'h0,        1, 3'd3, 0, 3'd0, 39'h0,     1, 32'h0F0F0F0F, 1, 0);
        vecs[13] = mk(1, 3'd3, 32'h0F0F0F0F, 0, 3'd0, 0, 3'd0, 39'h0,     0, 32'h0F0F0F0F, 1, 0);
        vecs[14] = mk(1, 3'd6, 32'h55,       0, 3'd0, 1, 3'd6, 39'h20,    0, 32'h0F0F0F0F, 1, 0);
        vecs[15] = mk(0, 3'd0, 32'h0,        1, 3'd6, 0, 3'd0, 39'h0,     1, 32'h55,       0, 0);
        vecs[16] = mk(0, 3'd0, 32'h0,        1, 3'd3, 0, 3'd0, 39'h0,     1, 32'h0F0F0F0F, 0, 0);
        vecs[17] = mk(1, 3'd7, 32'hCAFEF00D, 1, 3'd7, 1, 3'd7, 39'h3,     1, 32'h0,        0, 0);
        vecs[18] = mk(0, 3'd0, 32'h0,        1, 3'd7, 0, 3'd0, 39'h0,     1, 32'hCAFEF00D, 0, 0);
        vecs[19] = mk(0, 3'd0, 32'h0,        0, 3'd0, 1, 3'd7, 39'h40_0000_0000, 0, 32'hCAFEF00D, 0, 0);
        vecs[20] = mk(0, 3'd0, 32'h0,        1, 3'd7, 0, 3'd0, 39'h0,     1, 32'hCAFEF00D, 1, 0);
        vecs[21] = mk(1, 3'd7, 32'hCAFEF00D, 0, 3'd0, 0, 3'd0, 39'h0,     0, 32'hCAFEF00D, 1, 0);

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset rvalid", 64'(rvalid), 64'(0));
        chk("reset rdata", 64'(rdata), 64'(0));
        chk("reset busy", 64'(scrub_busy), 64'(0));
        chk("reset counters", 64'({corr_cnt, uncorr_cnt}), 64'(0));

        // Table-driven read/write/inject vectors, scrubber off
        for (int v = 0; v < 22; v++) begin
            we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
            re = vecs[v].re; raddr = vecs[v].raddr;
            inj_en = vecs[v].inj; inj_addr = vecs[v].iaddr; inj_mask = vecs[v].imask;
            @(negedge clk);
            chk($sformatf("vec%0d rvalid", v), 64'(rvalid), 64'(vecs[v].ev));
            chk($sformatf("vec%0d rdata", v), 64'(rdata), 64'(vecs[v].ed));
            chk($sformatf("vec%0d single", v), 64'(rerr_single), 64'(vecs[v].es));
            chk($sformatf("vec%0d double", v), 64'(rerr_double), 64'(vecs[v].edb));
        end
        idle_a();
        chk("reads leave corr_cnt", 64'(corr_cnt), 64'(0));
        chk("reads leave uncorr_cnt", 64'(uncorr_cnt), 64'(0));
        chk("busy while disabled", 64'(scrub_busy), 64'(0));

        // Scrub pass 1: addr2 single gets fixed, addr5 double gets counted
        scrub_en = 1'b1;
        @(negedge clk);
        chk("busy after enable", 64'(scrub_busy), 64'(1));
        wait_uncorr(8'd1, 8 * 18 + 8, "pass1 uncorr_cnt");
        chk("pass1 corr_cnt", 64'(corr_cnt), 64'(1));
        read_a(3'd2, 32'hDEADBEEF, 1'b0, 1'b0, "scrubbed addr2");

        // Scrub pass 2: double stays double, counted again
        wait_uncorr(8'd2, 8 * 18 + 8, "pass2 uncorr_cnt");
        chk("pass2 corr_cnt", 64'(corr_cnt), 64'(1));
        read_a(3'd5, 32'h0, 1'b0, 1'b1, "still double addr5");

        // Fix cancel: user write lands in the CHECK cycle of addr4
        inject_a(3'd3, 39'h20);
        inject_a(3'd4, 39'h20);
        wait_corr(8'd2, 8 * 18 + 8, "addr3 corr_cnt");
        repeat (17) @(negedge clk);
        we = 1'b1; waddr = 3'd4; wdata = 32'h12345678;
        @(negedge clk);
        we = 1'b0;
        chk("cancel corr_cnt", 64'(corr_cnt), 64'(3));
        repeat (3) @(negedge clk);
        read_a(3'd4, 32'h12345678, 1'b0, 1'b0, "cancelled fix addr4");
        read_a(3'd3, 32'h0F0F0F0F, 1'b0, 1'b0, "scrubbed addr3");

        // Disable scrubber, then reset mid-operation
        scrub_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy after disable", 64'(scrub_busy), 64'(0));
        scrub_en = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async reset busy", 64'(scrub_busy), 64'(0));
        chk("async reset counters", 64'({corr_cnt, uncorr_cnt}), 64'(0));
        chk("async reset rdata", 64'(rdata), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        scrub_en = 1'b0;
        read_a(3'd2, 32'h0, 1'b0, 1'b0, "after reset addr2");
        read_a(3'd5, 32'h0, 1'b0, 1'b0, "after reset addr5");

        // Instance B: out-of-range writes, injections and reads
        b_we = 1'b1; b_waddr = 3'd6; b_wdata = 32'hFFFF;
        b_inj_en = 1'b1; b_inj_addr = 3'd7; b_inj_mask = 39'h3;
        @(negedge clk);
        b_we = 1'b0; b_inj_en = 1'b0;
        read_b(3'd6, "oor addr6");
        read_b(3'd7, "oor addr7");

        // Instance B: four doubles saturate the 2-bit counter
        for (int a = 0; a < 4; a++) begin
            b_inj_en = 1'b1; b_inj_addr = 3'(a); b_inj_mask = 39'h3;
            @(negedge clk);
        end
        b_inj_en = 1'b0;
        b_scrub_en = 1'b1;
        repeat (40) @(negedge clk);
        chk("b saturated uncorr", 64'(b_uncorr_cnt), 64'(3));
        chk("b corr zero", 64'(b_corr_cnt), 64'(0));

        // Clear held across further increments keeps counter at zero
        b_clr_cnt = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk($sformatf("b clear cycle %0d", c), 64'(b_uncorr_cnt), 64'(0));
        end
        b_clr_cnt = 1'b0;
        repeat (40) @(negedge clk);
        chk("b recount after clear", 64'(b_uncorr_cnt), 64'(3));
        b_scrub_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/secded_scrub_regfile.md
Name: secded_scrub_regfile

Overview:
- Parametric SECDED (extended Hamming) protected register file with a background scrubber and error counters.
- Generalises the fixed 11-bit Hamming register to any data width and depth.
- Adds read-time correction, periodic scrub and write-back repair, saturating corrected/uncorrectable counters, and a fault-injection port for the FT benches.
- Sits beside the other FT mechanisms (triple_reg, sbf_reg, com_tr) for area/frequency comparison and is usable as a protected configuration/state store.

Parameters:
- DATA_WIDTH, 32: data bits per word.
- DEPTH, 8: number of words, >=2.
- SCRUB_PERIOD, 16: idle cycles between scrub steps, >=1.
- CNT_WIDTH, 8: width of each error counter.
- Derived P: smallest p with 2^p >= DATA_WIDTH+p+1. Derived CW = DATA_WIDTH+P+1 (extra overall-parity bit). Derived AW = $clog2(DEPTH).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- we_i  in  1  write strobe.
- waddr_i  in  AW  write address.
- wdata_i  in  DATA_WIDTH  write data.
- re_i  in  1  read strobe.
- raddr_i  in  AW  read address.
- rdata_o  out  DATA_WIDTH  corrected read data.
- rvalid_o  out  1  rdata_o and flags valid.
- rerr_single_o  out  1  read word had a corrected single error.
- rerr_double_o  out  1  read word had an uncorrectable error.
- scrub_en_i  in  1  enable background scrubber.
- scrub_busy_o  out  1  FSM not IDLE.
- clr_cnt_i  in  1  clear both counters.
- corr_cnt_o  out  CNT_WIDTH  scrub-corrected error count.
- uncorr_cnt_o  out  CNT_WIDTH  scrub-uncorrectable error count.
- inj_en_i  in  1  fault-injection strobe.
- inj_addr_i  in  AW  injection target.
- inj_mask_i  in  CW  bits XORed into the stored codeword.

Behaviour:
- Storage: DEPTH flop entries of CW bits, even parity.
- Reset: every entry = all-zero codeword (a valid encoding of data 0). All outputs 0, FSM IDLE, scrub pointer 0.
- Write: we_i encodes wdata_i and stores it at the next edge.
- Read: re_i registers the address and decodes. One cycle later rvalid_o=1 with rdata_o and flags; otherwise rvalid_o=0 and rdata_o/flags hold their previous values.
- Read sees the pre-edge contents: a same-cycle write to the same address returns the old word.
- Decode results:
  - Syndrome 0 and parity OK: clean.
  - Parity bad: single error, correct the flipped bit (syndrome 0 means the parity bit itself flipped).
  - Syndrome !=0 and parity OK: double error; rdata_o = raw stored data bits.
- Reads never write back and never touch the counters.
- Out-of-range addresses (>=DEPTH): writes and injections ignored; reads return 0 with rvalid_o=1 and both flags 0.
- Per-entry update priority each edge: user write > scrub fix > injection. The lower-priority update to the same entry is dropped. Different entries may update in the same cycle.
- Scrub FSM:
  - IDLE: if scrub_en_i, load wait counter with SCRUB_PERIOD-1 and go to WAIT.
  - WAIT: decrement; at 0 go to CHECK.
  - CHECK: decode entry[ptr].
    - Single error: latch the corrected codeword, corr_cnt++, go to FIX.
    - Double error: uncorr_cnt++, ptr++, go to WAIT.
    - Clean: ptr++, go to WAIT.
  - FIX: write the corrected codeword to entry[ptr], ptr++, go to WAIT.
  - The fix is cancelled (no write-back; counter already incremented) if a user write hits ptr in the CHECK or FIX cycle.
  - ptr wraps DEPTH-1 -> 0.
  - Each WAIT entry reloads SCRUB_PERIOD-1.
  - scrub_en_i low: WAIT/CHECK go to IDLE at the next edge without counting; FIX completes, then goes to IDLE. ptr is retained.
- Counters:
  - Saturate at 2^CNT_WIDTH-1.
  - clr_cnt_i zeroes both; clear wins over a same-cycle increment.
- Reset asserted mid-operation: immediate return to reset state; stored contents are lost.

Test Plan:
- Reset, re_i at addr 3 -> next cycle rvalid_o=1, rdata_o=0, both flags 0, scrub_busy_o=0.
- Write 0xDEADBEEF to addr 2, read addr 2 -> rdata_o=0xDEADBEEF one cycle after re_i, flags 0. Same-cycle write 0x1 plus read of addr 2 -> returns 0xDEADBEEF.
- Inject mask bit 5 at addr 2, read -> rdata_o=0xDEADBEEF, rerr_single_o=1, counters 0. Enable scrub -> within DEPTH*(SCRUB_PERIOD+2) cycles corr_cnt_o=1; a re-read then gives rerr_single_o=0.
- Inject mask bits 0 and 1 at addr 5 -> read rerr_double_o=1. After one scrub pass uncorr_cnt_o=1; after a second pass uncorr_cnt_o=2, word still flagged double.
- Single error at addr 4, user write 0x12345678 to addr 4 during the scrubber's CHECK cycle -> stored data 0x12345678 (fix cancelled), corr_cnt_o=1.
- CNT_WIDTH=2, four double errors scrubbed -> uncorr_cnt_o=3 (saturated). clr_cnt_i coincident with an increment -> 0.
